bus_sequencer: RTL
==================

BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 17, shared-bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, shared-bus data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 15, ack wait limit; used only with the timeout feature.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  3  per-requester access request, level; bit 0 = CPU, 1 = video, 2 = MCU/SPI.
REQ-007 req_addr  input  3*ADDR_WIDTH  per-requester address, requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 req_we  input  3  per-requester write enable (1 = write).
REQ-009 req_wdata  input  3*DATA_WIDTH  per-requester write data, same slicing as req_addr.
REQ-010 grant  output  3  one-hot owner of the bus, 0 when idle.
REQ-011 done  output  3  one-cycle completion pulse to the granted requester.
REQ-012 rdata  output  DATA_WIDTH  read data of the last completed read.
REQ-013 bus_addr, bus_we, bus_wdata  output  ADDR_WIDTH/1/DATA_WIDTH  latched transaction to the shared bus.
REQ-014 bus_strobe  output  1  one-cycle transaction start pulse to the bus sync stage.
REQ-015 bus_ack  input  1  completion from the bus sync stage.
REQ-016 bus_rdata  input  DATA_WIDTH  read data, valid while bus_ack = 1.
REQ-017 timeout  output  1  one-cycle pulse: transaction aborted for lack of ack.

Function
REQ-018 SHALL implement states IDLE, STROBE, WAIT, DONE.
REQ-019 IDLE: if any req bit set, SHALL select one requester round-robin starting after last_owner, latch its addr/we/wdata onto bus_*, set grant one-hot, go STROBE; else stay IDLE.
REQ-020 Latency: req sampled high at edge N SHALL produce grant and bus_strobe high after edge N+1 (one cycle after the arbitration edge).
REQ-021 STROBE: bus_strobe SHALL be 1 for exactly this one cycle; if bus_ack = 1 go DONE, else go WAIT.
REQ-022 WAIT: bus_strobe = 0; on bus_ack = 1 go DONE, else stay.
REQ-023 On the ack edge of a read (bus_we = 0), rdata SHALL capture bus_rdata; writes leave rdata unchanged.
REQ-024 DONE: done[owner] = 1 for exactly one cycle, grant held; then grant cleared, last_owner = owner, go IDLE.
REQ-025 Requester SHALL drop req by the DONE cycle; a req still high in IDLE is re-arbitrated at lowest priority.
REQ-026 Deasserting req after grant SHALL NOT abort the transaction; latched values complete.
REQ-027 bus_addr/bus_we/bus_wdata SHALL remain stable from STROBE through DONE.
REQ-028 Simultaneous requests: winner is first set bit in order last_owner+1, +2, +3 (mod 3); no requester waits more than two other transactions.
REQ-029 bus_ack outside STROBE/WAIT SHALL be ignored.
REQ-030 At most one bit of grant and done SHALL ever be set.

Reset
REQ-031 reset SHALL force IDLE, grant = 0, done = 0, bus_strobe = 0, timeout = 0, bus_addr = 0, bus_we = 0, bus_wdata = 0, rdata = 0, last_owner = 2 (CPU wins first).
REQ-032 reset asserted mid-transaction SHALL abandon it without done or timeout pulse.

Configuration
REQ-033 Macro BUS_SEQUENCER_TIMEOUT_EN defined: counter counts cycles in STROBE+WAIT; reaching TIMEOUT_CYCLES without ack goes DONE with done[owner] = 1, timeout = 1, rdata = all ones.
REQ-034 Macro undefined: no counter; WAIT holds indefinitely; timeout tied 0.

Verification
REQ-035 Reset, req = 0 -> grant = 0, done = 0, bus_strobe = 0, rdata = 0 indefinitely.
REQ-036 req = 3'b001 read addr 17'h08000, bus_ack 2 cycles after strobe with bus_rdata 8'hA5 -> strobe one cycle after arbitration, done = 3'b001 one cycle, rdata = 8'hA5.
REQ-037 req = 3'b111 held continuously, ack in STROBE -> grants cycle 001, 010, 100, 001; each done one cycle.
REQ-038 MCU write addr 17'h1FFFF data 8'h3C, ack same cycle as strobe -> bus_we = 1, bus_wdata = 8'h3C through DONE, rdata unchanged.
REQ-039 reset pulsed in WAIT -> next cycle IDLE, all outputs at reset values, no done pulse.
REQ-040 With BUS_SEQUENCER_TIMEOUT_EN, TIMEOUT_CYCLES = 15, no ack -> 15 cycles after strobe, done and timeout pulse together, rdata = 8'hFF.

Source files
------------

// File: rtl/bus_sequencer.sv
// bus_sequencer: round-robin arbiter and transaction sequencer for a shared bus
// used by three requesters (0 = CPU, 1 = video, 2 = MCU/SPI).
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req[2:0]                   per-requester access request (level)
//   req_addr / req_we /        per-requester transaction, requester i at
//   req_wdata                  slice [i*W +: W]
//   grant[2:0]                 one-hot bus owner, 0 when idle
//   done[2:0]                  one-cycle completion pulse to the owner
//   rdata                      read data of the last completed read
//   bus_addr/bus_we/bus_wdata  transaction latched toward the bus
//   bus_strobe                 one-cycle transaction start pulse
//   bus_ack, bus_rdata         completion and read data from the bus side
//   timeout                    one-cycle pulse when a transaction is aborted
//
// Optional feature: define BUS_SEQUENCER_TIMEOUT_EN to abort transactions that
// see no bus_ack within TIMEOUT_CYCLES cycles of STROBE+WAIT. Without it the
// sequencer waits for bus_ack indefinitely and timeout is tied low.
module bus_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 17,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              req,
  input  logic [3*ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]              req_we,
  input  logic [3*DATA_WIDTH-1:0] req_wdata,
  output logic [2:0]              grant,
  output logic [2:0]              done,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic                    bus_we,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic                    bus_strobe,
  input  logic                    bus_ack,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  output logic                    timeout
);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

  state_t                 state, state_d;
  logic [2:0]             req_q;
  logic [1:0]             owner, owner_d;
  logic [1:0]             last_owner, last_owner_d;
  logic [2:0]             grant_d, done_d;
  logic [DATA_WIDTH-1:0]  rdata_d;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic                   we_d;
  logic [DATA_WIDTH-1:0]  wdata_d;
  logic                   strobe_d;

  logic                   win_valid;
  logic [1:0]             win, cand;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic                   win_we;
  logic [DATA_WIDTH-1:0]  win_wdata;

`ifdef BUS_SEQUENCER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             timeout_d;
`else
  // The ack wait limit has no hardware in this build.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
  assign timeout = 1'b0;
`endif

  // Round-robin pick: first pending requester after last_owner (mod 3).
  // Searching from the far end down leaves the nearest candidate as winner.
  always_comb begin
    win_valid = 1'b0;
    win       = 2'd0;
    cand      = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      cand = 2'((int'(last_owner) + k) % 3);
      if (req_q[cand]) begin
        win_valid = 1'b1;
        win       = cand;
      end
    end
  end

  // Select the winner's transaction fields.
  always_comb begin
    win_addr  = req_addr[0 +: ADDR_WIDTH];
    win_we    = req_we[0];
    win_wdata = req_wdata[0 +: DATA_WIDTH];
    case (win)
      2'd1: begin
        win_addr  = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
        win_we    = req_we[1];
        win_wdata = req_wdata[DATA_WIDTH +: DATA_WIDTH];
      end
      2'd2: begin
        win_addr  = req_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
        win_we    = req_we[2];
        win_wdata = req_wdata[2*DATA_WIDTH +: DATA_WIDTH];
      end
      default: ;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_owner_d = last_owner;
    grant_d      = grant;
    done_d       = 3'b000;
    strobe_d     = 1'b0;
    rdata_d      = rdata;
    addr_d       = bus_addr;
    we_d         = bus_we;
    wdata_d      = bus_wdata;
`ifdef BUS_SEQUENCER_TIMEOUT_EN
    cnt_d        = cnt;
    timeout_d    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (win_valid) begin
          state_d  = STROBE;
          owner_d  = win;
          grant_d  = 3'b001 << win;
          strobe_d = 1'b1;
          addr_d   = win_addr;
          we_d     = win_we;
          wdata_d  = win_wdata;
`ifdef BUS_SEQUENCER_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      STROBE, WAIT: begin
        if (bus_ack) begin
          state_d = DONE;
          done_d  = grant;
          if (!bus_we) rdata_d = bus_rdata;
        end
`ifdef BUS_SEQUENCER_TIMEOUT_EN
        // cnt holds the STROBE/WAIT cycles already finished before this one.
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = DONE;
          done_d    = grant;
          timeout_d = 1'b1;
          rdata_d   = '1;
        end else begin
          cnt_d   = cnt + CNT_W'(1);
          state_d = WAIT;
        end
`else
        else begin
          state_d = WAIT;
        end
`endif
      end
      DONE: begin
        state_d      = IDLE;
        grant_d      = 3'b000;
        last_owner_d = owner;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; req is registered once ahead of arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_q      <= 3'b000;
      owner      <= 2'd0;
      last_owner <= 2'd2;
      grant      <= 3'b000;
      done       <= 3'b000;
      bus_strobe <= 1'b0;
      rdata      <= '0;
      bus_addr   <= '0;
      bus_we     <= 1'b0;
      bus_wdata  <= '0;
`ifdef BUS_SEQUENCER_TIMEOUT_EN
      cnt        <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      req_q      <= req;
      owner      <= owner_d;
      last_owner <= last_owner_d;
      grant      <= grant_d;
      done       <= done_d;
      bus_strobe <= strobe_d;
      rdata      <= rdata_d;
      bus_addr   <= addr_d;
      bus_we     <= we_d;
      bus_wdata  <= wdata_d;
`ifdef BUS_SEQUENCER_TIMEOUT_EN
      cnt        <= cnt_d;
      timeout    <= timeout_d;
`endif
    end
  end

endmodule
